// File: rtl/mem_req_pkg.sv
// Shared types and default constants for the memory requester.
// The wait-counter helper is only used when MEM_REQ_TIMEOUT_EN is defined.
package mem_req_pkg;

    localparam int unsigned DEF_ADDR_LENGTH = 10;
    localparam int unsigned DEF_BLOCK_SIZE  = 32;
    localparam int unsigned DEF_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Counter only needs to reach max_count-1, so at least one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/mem_req_timeout.sv
// Saturating READ wait counter; expired marks the TIMEOUT-th cycle spent waiting.
// Compiled only when MEM_REQ_TIMEOUT_EN is defined.
`ifdef MEM_REQ_TIMEOUT_EN
module mem_req_timeout
    import mem_req_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule
`endif

// File: rtl/mem_requester.sv
// Initiator for the main-memory enable/fetch-complete protocol, one request at a time.
// Define MEM_REQ_TIMEOUT_EN to bound the wait for fetch-complete to TIMEOUT cycles.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int unsigned ADDR_LENGTH = DEF_ADDR_LENGTH,
    parameter int unsigned BLOCK_SIZE  = DEF_BLOCK_SIZE,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_LENGTH-1:0] req_addr,
    input  logic [BLOCK_SIZE-1:0]  req_wdata,
    output logic                   resp_valid,
    output logic [BLOCK_SIZE-1:0]  resp_rdata,
    output logic                   resp_err,
    output logic                   mem_enable,
    output logic                   mem_write,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [BLOCK_SIZE-1:0]  mem_data_in,
    input  logic [BLOCK_SIZE-1:0]  mem_data_out,
    input  logic                   mem_fetch_complete
);

    // state | meaning
    // IDLE  | ready for a request
    // WRITE | write strobe on the memory for one cycle
    // READ  | enable held until fetch-complete (or timeout)
    // DRAIN | wait for a stale fetch-complete to clear

    state_e                 state_q,       state_d;
    logic                   req_ready_q,   req_ready_d;
    logic                   resp_valid_q,  resp_valid_d;
    logic [BLOCK_SIZE-1:0]  resp_rdata_q,  resp_rdata_d;
    logic                   resp_err_q,    resp_err_d;
    logic                   mem_enable_q,  mem_enable_d;
    logic                   mem_write_q,   mem_write_d;
    logic [ADDR_LENGTH-1:0] mem_addr_q,    mem_addr_d;
    logic [BLOCK_SIZE-1:0]  mem_data_in_q, mem_data_in_d;

    logic accept;
    logic in_read;
    logic timed_out;

    assign accept  = req_valid && req_ready_q;
    assign in_read = (state_q == READ);

`ifdef MEM_REQ_TIMEOUT_EN
    mem_req_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (in_read),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_ready_d   = 1'b0;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        mem_enable_d  = 1'b0;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr_d    = req_addr;
                    mem_data_in_d = req_wdata;
                    if (req_write) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d      = READ;
                        mem_enable_d = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            WRITE: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b1;
            end
            READ: begin
                // Completion takes priority over a timeout on the same edge.
                if (mem_fetch_complete) begin
                    state_d      = DRAIN;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_data_out;
                end else if (timed_out) begin
                    state_d      = DRAIN;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    mem_enable_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!mem_fetch_complete) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= DRAIN;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_enable  = mem_enable_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;

    timeout_param_ok: assert property (@(posedge clk) TIMEOUT >= 1);

    enable_write_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(mem_enable_q && mem_write_q));

    // A completion flag while idle or writing means the memory broke protocol.
    no_stray_completion: assert property (@(posedge clk) disable iff (reset)
        ((state_q == IDLE) || (state_q == WRITE)) |-> !mem_fetch_complete);

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: directed scenarios plus randomized traffic
// against a transaction-level model and a latency-configurable memory.
module tb_mem_requester;

    localparam int AW         = 10;
    localparam int BW         = 32;
    localparam int TB_TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_wdata;
    logic          resp_valid;
    logic [BW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_enable;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data_in;
    logic [BW-1:0] mem_data_out;
    logic          mem_fetch_complete;

    always #5 clk = ~clk;

    mem_requester #(
        .ADDR_LENGTH (AW),
        .BLOCK_SIZE  (BW),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .resp_err           (resp_err),
        .mem_enable         (mem_enable),
        .mem_write          (mem_write),
        .mem_addr           (mem_addr),
        .mem_data_in        (mem_data_in),
        .mem_data_out       (mem_data_out),
        .mem_fetch_complete (mem_fetch_complete)
    );

    // Memory: completion after mem_delay enabled cycles, flag may linger a few cycles.
    logic [BW-1:0] mem [0:1023];
    int mem_delay;
    int en_cnt;
    int stale_left;
    bit mem_stuck;

    // Transaction-level expectation of the outputs for the current cycle.
    bit            m_ready, m_resp, m_err, m_en, m_wr, m_drain;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_din, m_rdata;
    int            m_wait;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            obs_resp = 0, obs_err = 0, obs_en_cycles = 0, obs_en_rises = 0, obs_wr_cycles = 0;
    bit            prev_en = 1'b0;
    bit            obs_ready_at_resp;
    logic [BW-1:0] resp_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_ready = 0; m_resp = 0; m_err = 0; m_en = 0; m_wr = 0; m_drain = 1;
            m_addr = '0; m_din = '0; m_rdata = '0; m_wait = 0;
        end else begin
            m_resp = 0;
            m_err  = 0;
            if (m_ready) begin
                if (req_valid) begin
                    m_ready = 0;
                    m_addr  = req_addr;
                    m_din   = req_wdata;
                    m_wr    = req_write;
                    m_en    = !req_write;
                    m_wait  = 0;
                end
            end else if (m_wr) begin
                m_wr = 0; m_ready = 1; m_resp = 1;
            end else if (m_en) begin
                m_wait++;
                if (mem_fetch_complete) begin
                    m_rdata = mem_data_out; m_resp = 1; m_en = 0; m_drain = 1;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (m_wait >= TB_TIMEOUT) begin
                    m_resp = 1; m_err = 1; m_en = 0; m_drain = 1;
                end
`endif
            end else if (m_drain) begin
                if (!mem_fetch_complete) begin
                    m_drain = 0; m_ready = 1;
                end
            end
        end
    endtask

    // One cycle, called at a negedge: compare, advance memory, drive inputs, advance model.
    task automatic tick(input bit rv, input bit rw, input logic [AW-1:0] ra,
                        input logic [BW-1:0] rd, input bit rst);
        cyc++;
        check("req_ready",   64'(req_ready),   64'(m_ready));
        check("resp_valid",  64'(resp_valid),  64'(m_resp));
        check("resp_err",    64'(resp_err),    64'(m_err));
        check("resp_rdata",  64'(resp_rdata),  64'(m_rdata));
        check("mem_enable",  64'(mem_enable),  64'(m_en));
        check("mem_write",   64'(mem_write),   64'(m_wr));
        check("mem_addr",    64'(mem_addr),    64'(m_addr));
        check("mem_data_in", 64'(mem_data_in), 64'(m_din));
        check("enable_write_excl", 64'(mem_enable && mem_write), 64'(0));

        if (resp_valid === 1'b1) begin
            obs_resp++;
            obs_ready_at_resp = req_ready;
            resp_log.push_back(resp_rdata);
            if (resp_err === 1'b1) obs_err++;
        end
        if (mem_enable === 1'b1) begin
            obs_en_cycles++;
            if (!prev_en) obs_en_rises++;
        end
        prev_en = (mem_enable === 1'b1);
        if (mem_write === 1'b1) obs_wr_cycles++;

        if (mem_write === 1'b1) mem[mem_addr] = mem_data_in;
        if (mem_enable === 1'b1) begin
            en_cnt++;
            mem_fetch_complete = !mem_stuck && (en_cnt > mem_delay);
            stale_left = $urandom_range(0, 3);
        end else begin
            en_cnt = 0;
            if (mem_fetch_complete && stale_left > 0) stale_left--;
            else mem_fetch_complete = 1'b0;
        end
        mem_data_out = mem[mem_addr];

        reset     = rst;
        req_valid = rv;
        req_write = rw;
        req_addr  = ra;
        req_wdata = rd;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0);
    endtask

    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            done = m_ready;
            tick(1, w, a, d, 0);
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL accept_wait: request addr %0h not accepted within 50 cycles, expected acceptance", a);
        end
    endtask

    task automatic wait_resp(input int target, input int max, output int waited);
        waited = 0;
        while (obs_resp < target && waited < max) begin
            tick(0, 0, '0, '0, 0);
            waited++;
        end
        if (obs_resp < target) begin
            n_checks++; n_fail++;
            $display("FAIL resp_wait: got %0d responses, expected %0d within %0d cycles", obs_resp, target, max);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, r0, e0, x0, l0;
        for (int i = 0; i < 1024; i++) mem[i] = BW'(i);
        reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        mem_fetch_complete = 0; mem_data_out = '0;
        mem_delay = 5; en_cnt = 0; stale_left = 0; mem_stuck = 0;
        repeat (2) @(negedge clk);
        model_step();

        tick(0, 0, '0, '0, 1);
        check("reset_ready", 64'(req_ready), 64'(0));
        check("reset_rdata", 64'(resp_rdata), 64'(0));
        tick(0, 0, '0, '0, 0);
        check("ready_after_drain", 64'(req_ready), 64'(1));

        // Read 10 with a 5-cycle memory
        r0 = obs_resp; e0 = obs_en_cycles;
        do_req(0, 10, '0);
        wait_resp(r0 + 1, 30, w);
        check("read10_data", 64'(resp_log[resp_log.size()-1]), 64'(10));
        check("read10_enable_cycles", 64'(obs_en_cycles - e0), 64'(6));
        check("read10_ready_in_resp", 64'(obs_ready_at_resp), 64'(0));
        idle(5);
        check("read10_single_pulse", 64'(obs_resp - r0), 64'(1));

        // Write 50 then read it back
        x0 = obs_wr_cycles; r0 = obs_resp;
        do_req(1, 50, 32'hDEAD);
        wait_resp(r0 + 1, 10, w);
        check("write_latency", 64'(w), 64'(2));
        idle(3);
        check("write_strobe_cycles", 64'(obs_wr_cycles - x0), 64'(1));
        r0 = obs_resp;
        do_req(0, 50, '0);
        wait_resp(r0 + 1, 30, w);
        check("read50_data", 64'(resp_log[resp_log.size()-1]), 64'(32'hDEAD));

        // Back-to-back reads with req_valid held
        idle(2);
        r0 = obs_resp; l0 = resp_log.size(); x0 = obs_en_rises;
        do_req(0, 3, '0);
        do_req(0, 4, '0);
        wait_resp(r0 + 2, 30, w);
        check("b2b_first",  64'(resp_log[l0]),   64'(3));
        check("b2b_second", 64'(resp_log[l0+1]), 64'(4));
        check("b2b_enable_bursts", 64'(obs_en_rises - x0), 64'(2));

        // Zero-delay memory
        idle(2);
        mem_delay = 0;
        r0 = obs_resp; e0 = obs_en_cycles;
        do_req(0, 7, '0);
        wait_resp(r0 + 1, 10, w);
        check("zero_delay_data", 64'(resp_log[resp_log.size()-1]), 64'(7));
        check("zero_delay_enable_cycles", 64'(obs_en_cycles - e0), 64'(1));
        idle(4);
        mem_delay = 5;

        // Reset two cycles into a read
        r0 = obs_resp;
        do_req(0, 20, '0);
        idle(1);
        tick(0, 0, '0, '0, 1);
        check("reset_drops_enable", 64'(mem_enable), 64'(0));
        idle(12);
        check("reset_no_response", 64'(obs_resp - r0), 64'(0));
        do_req(0, 21, '0);
        wait_resp(r0 + 1, 30, w);
        check("read21_data", 64'(resp_log[resp_log.size()-1]), 64'(21));

`ifdef MEM_REQ_TIMEOUT_EN
        idle(4);
        mem_stuck = 1;
        r0 = obs_resp; e0 = obs_en_cycles; x0 = obs_err;
        do_req(0, 5, '0);
        wait_resp(r0 + 1, 30, w);
        check("timeout_err", 64'(obs_err - x0), 64'(1));
        check("timeout_enable_cycles", 64'(obs_en_cycles - e0), 64'(TB_TIMEOUT));
        mem_stuck = 0;
        idle(3);
        r0 = obs_resp;
        do_req(0, 6, '0);
        wait_resp(r0 + 1, 30, w);
        check("after_timeout_data", 64'(resp_log[resp_log.size()-1]), 64'(6));
`endif

        // Randomized traffic on a small address window so reads hit earlier writes
        for (int i = 0; i < 3000; i++) begin
            if (!mem_enable && !mem_fetch_complete) mem_delay = $urandom_range(0, 4);
            tick(($urandom % 3) != 0, $urandom % 2 == 1, AW'($urandom_range(0, 15)),
                 $urandom, ($urandom % 300) == 0);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
